datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Control FSM that sits directly upstream of the 5-bit register/adder/shift-register/mux datapath and drives its mux select, register load and shift direction. It replaces the divided-clock scheme with a single clock plus an internal tick enable. On a debounced start press it runs a latched operation for a programmed number of ticks, then returns the datapath to hold. The top level instantiates it between the board keys/switches and the datapath.

## Interface
- TICK_DIV, 26, tick period = 2^TICK_DIV clk cycles (range 1..31)
- REPEAT_W, 3, width of the repeat-count input
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  raw start request, active-high (asynchronous to clk)
- op  in  2  operation code: 0 hold, 1 add, 2 shift, 3 switch-load
- dir  in  1  shift direction request: 1 right, 0 left
- repeat_n  in  REPEAT_W  number of execute ticks; 0 is treated as 1
- sel  out  2  datapath mux select
- load  out  1  register load enable, one-cycle pulse
- shift_r  out  1  shift direction to the shift register
- tick  out  1  one-cycle enable strobe, also consumed by the datapath
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Tick generator: TICK_DIV-bit free-running counter; tick=1 for the single cycle where the counter is all ones; wraps to 0.
- Start path: 2-flop synchronizer, then a rising-edge detector gives start_pulse. start_pulse is 3 cycles after the first clk edge that samples start high. Holding start high gives exactly one pulse.
- States: IDLE, ARM, EXEC, DONE.
- IDLE: sel=0, load=0. On start_pulse, latch op, dir and repeat_n (0 becomes 1) into op_q, dir_q and rem, then go to ARM.
- ARM: sel=op_q, load=0. On tick, go to EXEC.
- EXEC: sel=op_q, load=tick. On each tick, decrement rem. On the tick where rem==1, go to DONE.
- DONE: done=1 for one cycle, sel=0, then go to IDLE.
- shift_r=dir_q in ARM and EXEC, otherwise 0.
- busy=(state!=IDLE).
- start_pulse while busy is ignored and not queued. Inputs op, dir and repeat_n are sampled only on the start_pulse cycle.
- rem width is REPEAT_W. The maximum run is 2^REPEAT_W-1 ticks, and rem never wraps.

## Timing
- Reset values: state=IDLE, tick counter=0, synchronizer flops=0, sel=0, load=0, shift_r=0, tick=0, busy=0, done=0.
- sel, shift_r, busy and done are registered from state.
- load is combinational: (state==EXEC)&tick. It is asserted in the same cycle as tick, so the datapath register captures on that edge.
- The ARM→EXEC transition consumes one tick and does not load. Load pulses occur on the following repeat_n ticks.
- done is asserted in the cycle after the last load pulse.
- A tick in the same cycle as start_pulse is not counted; ARM waits for the next tick.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values. There is no done pulse, and the tick counter restarts from 0.

## Structure
- Package ctrl_pkg holds:
  - the state enum (IDLE, ARM, EXEC, DONE)
  - op localparams OP_HOLD=0, OP_ADD=1, OP_SHIFT=2, OP_SW=3
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick). It is reusable by the datapath top level.
- Synchronizer, edge detector and FSM stay in datapath_ctrl.

## Test plan
All scenarios use TICK_DIV=2, so tick fires every 4 cycles.
- Reset held for 5 cycles, then released → all outputs 0. First tick occurs on the 4th cycle after release, then every 4 cycles.
- start held high for 20 cycles with op=1, repeat_n=3 → exactly one run: busy rises, sel=1, 3 load pulses each coincident with tick, done one cycle after the 3rd load, then busy=0 and sel=0.
- op=2, dir=1, repeat_n=0 → exactly 1 load pulse, shift_r=1 during ARM/EXEC, 0 after done.
- Second start edge during EXEC, and op changed to 3 mid-run → no extra loads; sel stays at the latched op until DONE.
- reset asserted in EXEC after the 1st of 5 loads → state IDLE next cycle, no done pulse, tick counter restarts from 0.
- repeat_n=7 (maximum) → 7 load pulses then done; rem ends at 0 with no wrap.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the datapath control FSM.
package ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StExec,
        StDone
    } state_e;

    localparam logic [1:0] OP_HOLD  = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_SHIFT = 2'd2;
    localparam logic [1:0] OP_SW    = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle enable every 2^TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 26
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [TICK_DIV-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TICK_DIV'(1);
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/datapath_ctrl.sv
// Control FSM for the register/adder/shift datapath: debounced start, latched op,
// tick-paced execution of a programmed number of load cycles.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 26,
    parameter int unsigned REPEAT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic                dir,
    input  logic [REPEAT_W-1:0] repeat_n,
    output logic [1:0]          sel,
    output logic                load,
    output logic                shift_r,
    output logic                tick,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                dir_q, dir_d;
    logic [REPEAT_W-1:0] rem_q, rem_d;
    logic                sync1_q, sync2_q, sync3_q, start_pulse_q;
    logic [1:0]          sel_q, sel_d;
    logic                shift_r_q, shift_r_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                run_d;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start_pulse_q) begin
                    op_d    = op;
                    dir_d   = dir;
                    rem_d   = (repeat_n == '0) ? REPEAT_W'(1) : repeat_n;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (tick) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (tick) begin
                    rem_d = rem_q - REPEAT_W'(1);
                    if (rem_q == REPEAT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        run_d     = (state_d == StArm) || (state_d == StExec);
        sel_d     = run_d ? op_d : OP_HOLD;
        shift_r_d = run_d & dir_d;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            op_q          <= OP_HOLD;
            dir_q         <= 1'b0;
            rem_q         <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            start_pulse_q <= 1'b0;
            sel_q         <= OP_HOLD;
            shift_r_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            dir_q         <= dir_d;
            rem_q         <= rem_d;
            sync1_q       <= start;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            start_pulse_q <= sync2_q & ~sync3_q;
            sel_q         <= sel_d;
            shift_r_q     <= shift_r_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Combinational so the datapath register captures on the tick edge itself.
    assign load    = (state_q == StExec) & tick;
    assign sel     = sel_q;
    assign shift_r = shift_r_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: expected load/done events queued at stimulus time.
module tb_datapath_ctrl;

    localparam int unsigned TICK_DIV = 2;
    localparam int unsigned REPEAT_W = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          op = 2'd0;
    logic                dir = 1'b0;
    logic [REPEAT_W-1:0] repeat_n = '0;
    logic [1:0]          sel;
    logic                load, shift_r, tick, busy, done;

    typedef struct {
        bit         is_done;
        logic [1:0] sel;
        logic       shift_r;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_load_cyc = -10;
    int         loads_seen = 0;
    bit         mon_en = 1'b0;
    bit         busy_seen = 1'b0;
    logic [1:0] run_sel = 2'd0;
    logic       run_dir = 1'b0;

    datapath_ctrl #(
        .TICK_DIV(TICK_DIV),
        .REPEAT_W(REPEAT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .dir     (dir),
        .repeat_n(repeat_n),
        .sel     (sel),
        .load    (load),
        .shift_r (shift_r),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every load/done must match the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_seen = 1'b1;
            if (load) begin
                loads_seen++;
                n_checks++;
                if (tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_tick: tick=%b required 1 at cycle %0d", tick, cyc);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_load: load=1 required 0 at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_done || sel !== mon_e.sel || shift_r !== mon_e.shift_r) begin
                        n_fail++;
                        $display("FAIL load_event: load sel=%0d shift_r=%b, required %s sel=%0d shift_r=%b",
                                 sel, shift_r, mon_e.is_done ? "done" : "load", mon_e.sel,
                                 mon_e.shift_r);
                    end
                end
                last_load_cyc = cyc;
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_done: done=1 required 0 at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_done || sel !== 2'd0 || shift_r !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done_event: done sel=%0d shift_r=%b, required %s sel=0 shift_r=0",
                                 sel, shift_r, mon_e.is_done ? "done" : "load");
                    end
                end
                n_checks++;
                if (cyc != last_load_cyc + 1) begin
                    n_fail++;
                    $display("FAIL done_timing: done at cycle %0d, required cycle %0d",
                             cyc, last_load_cyc + 1);
                end
            end
            if (busy && !done) begin
                n_checks++;
                if (sel !== run_sel || shift_r !== run_dir) begin
                    n_fail++;
                    $display("FAIL run_outputs: sel=%0d shift_r=%b, required sel=%0d shift_r=%b",
                             sel, shift_r, run_sel, run_dir);
                end
            end
        end
    end

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_run(input int n, input logic [1:0] s, input logic d);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.is_done = 1'b0;
            e.sel     = s;
            e.shift_r = d;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.sel     = 2'd0;
        e.shift_r = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1 start = 1'b1;
        repeat (n) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sel, load, shift_r, tick, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: {sel,load,shift_r,tick,busy,done}=%b required 0000000",
                     {sel, load, shift_r, tick, busy, done});
        end
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            n_checks++;
            if (tick !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL reset_tick_phase: cycle %0d tick=%b required %b",
                         k, tick, (k % 4) == 0);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_add_hold;
        bit ok;
        op = 2'd1; dir = 1'b0; repeat_n = 3'd3;
        run_sel = 2'd1; run_dir = 1'b0;
        busy_seen = 1'b0;
        push_run(3, 2'd1, 1'b0);
        pulse_start(20);
        wait_idle(80, ok);
        n_checks++;
        if (!ok || !busy_seen) begin
            n_fail++;
            $display("FAIL add_run: complete=%b busy_seen=%b pending=%0d, required 1 1 0",
                     ok, busy_seen, exp_q.size());
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || sel !== 2'd0) begin
                n_fail++;
                $display("FAIL add_single_run: busy=%b sel=%0d required 0 0", busy, sel);
            end
        end
    endtask

    task automatic test_shift_rep0;
        bit ok;
        op = 2'd2; dir = 1'b1; repeat_n = 3'd0;
        run_sel = 2'd2; run_dir = 1'b1;
        push_run(1, 2'd2, 1'b1);
        pulse_start(3);
        wait_idle(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL shift_rep0_run: complete=%b pending=%0d required 1 0", ok, exp_q.size());
        end
        n_checks++;
        if (shift_r !== 1'b0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL shift_after_done: shift_r=%b sel=%0d required 0 0", shift_r, sel);
        end
    endtask

    task automatic test_mid_run;
        bit ok;
        int base;
        op = 2'd1; dir = 1'b0; repeat_n = 3'd4;
        run_sel = 2'd1; run_dir = 1'b0;
        push_run(4, 2'd1, 1'b0);
        base = loads_seen;
        pulse_start(3);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (loads_seen > base) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_first_load: loads=%0d required >%0d", loads_seen, base);
        end
        @(posedge clk);
        #1 op = 2'd3; dir = 1'b1; repeat_n = 3'd7; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_idle(80, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_run: complete=%b pending=%0d required 1 0", ok, exp_q.size());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_not_queued: busy=%b required 0", busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int base;
        op = 2'd1; dir = 1'b0; repeat_n = 3'd5;
        run_sel = 2'd1; run_dir = 1'b0;
        push_run(1, 2'd1, 1'b0);
        void'(exp_q.pop_back());
        base = loads_seen;
        pulse_start(3);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (loads_seen > base) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_first_load: loads=%0d required >%0d", loads_seen, base);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sel, load, shift_r, tick, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: {sel,load,shift_r,tick,busy,done}=%b required 0000000",
                     {sel, load, shift_r, tick, busy, done});
        end
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            n_checks++;
            if (tick !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL rst_mid_tick_phase: cycle %0d tick=%b required %b",
                         k, tick, (k % 4) == 0);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_idle: busy=%b required 0", busy);
            end
        end
    endtask

    task automatic test_max_repeat;
        bit ok;
        op = 2'd3; dir = 1'b0; repeat_n = 3'd7;
        run_sel = 2'd3; run_dir = 1'b0;
        push_run(7, 2'd3, 1'b0);
        pulse_start(3);
        wait_idle(120, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL max_run: complete=%b pending=%0d required 1 0", ok, exp_q.size());
        end
        n_checks++;
        if (dut.rem_q !== 3'd0) begin
            n_fail++;
            $display("FAIL max_rem_final: rem=%0d required 0", dut.rem_q);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || load !== 1'b0) begin
                n_fail++;
                $display("FAIL max_no_wrap: busy=%b load=%b required 0 0", busy, load);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_hold;
        test_shift_rep0;
        test_mid_run;
        test_reset_mid;
        test_max_repeat;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
